// File: rtl/pp_bank_scheduler.sv
// Ping-pong two-bank scheduler: a producer fills one bank while the read FSM bursts the other into the array.
// Define PP_SCHED_ERR_EN to enable the sticky protocol-error flag; otherwise err is tied low.
module pp_bank_scheduler #(
    parameter int ADDR_WIDTH = 4,
    parameter int W_COL_X    = 4,
    parameter int N_COL_X    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_start,
    input  logic                  wr_done,
    output logic                  wr_ready,
    output logic                  wr_bank,
    input  logic                  acc_done_wrap,
    output logic                  rd_bank,
    output logic                  w_rd_en,
    output logic [ADDR_WIDTH-1:0] w_rd_addra,
    output logic [ADDR_WIDTH-1:0] w_rd_addrb,
    output logic                  n_rd_en,
    output logic [ADDR_WIDTH-1:0] n_rd_addr,
    output logic                  rd_data_valid,
    output logic                  enable_matmul,
    output logic [3:0]            bank_state,
    output logic                  err
);
    localparam int BURST = (W_COL_X > N_COL_X) ? W_COL_X : N_COL_X;
    localparam int KW    = $clog2(BURST) + 1;

    typedef enum logic [1:0] {B_EMPTY = 2'd0, B_FILLING = 2'd1, B_FULL = 2'd2, B_BUSY = 2'd3} bank_t;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_WAIT_ACC} rd_state_t;

    bank_t           bank [2];
    rd_state_t       rd_fsm;
    logic [KW-1:0]   k;
    logic            acc_prev;

    logic            wr_accept, wr_finish, acc_rise, rd_start, rd_release;
    logic [KW-1:0]   k_next;
    logic            beat_w_en, beat_n_en;
    logic [ADDR_WIDTH-1:0] beat_addra, beat_addrb, beat_naddr;

    assign wr_ready   = (bank[wr_bank] == B_EMPTY);
    assign wr_accept  = wr_start & wr_ready;
    assign wr_finish  = wr_done & (bank[wr_bank] == B_FILLING);
    assign acc_rise   = acc_done_wrap & ~acc_prev;
    assign rd_start   = (rd_fsm == S_IDLE) & (bank[rd_bank] == B_FULL);
    assign rd_release = (rd_fsm == S_WAIT_ACC) & acc_rise;
    assign bank_state = {bank[1], bank[0]};

    // Next beat to present: beat 0 when leaving idle, otherwise k+1.
    always_comb begin
        k_next     = (rd_fsm == S_READ) ? k + 1'b1 : '0;
        beat_w_en  = int'(k_next) < W_COL_X;
        beat_n_en  = int'(k_next) < N_COL_X;
        beat_addra = beat_w_en ? ADDR_WIDTH'(k_next) : '0;
        beat_addrb = beat_w_en ? ADDR_WIDTH'(W_COL_X + int'(k_next)) : '0;
        beat_naddr = beat_n_en ? ADDR_WIDTH'(k_next) : '0;
    end

    // Every legal transition needs a distinct source state, so write and read sides never collide on one bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) bank[b] <= B_EMPTY;
            wr_bank <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (wr_accept && wr_bank == 1'(b))
                    bank[b] <= B_FILLING;
                else if (wr_finish && wr_bank == 1'(b))
                    bank[b] <= B_FULL;
                else if (rd_start && rd_bank == 1'(b))
                    bank[b] <= B_BUSY;
                else if (rd_release && rd_bank == 1'(b))
                    bank[b] <= B_EMPTY;
            end
            wr_bank <= wr_bank ^ wr_finish;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_fsm        <= S_IDLE;
            rd_bank       <= 1'b0;
            k             <= '0;
            acc_prev      <= 1'b0;
            w_rd_en       <= 1'b0;
            w_rd_addra    <= '0;
            w_rd_addrb    <= '0;
            n_rd_en       <= 1'b0;
            n_rd_addr     <= '0;
            rd_data_valid <= 1'b0;
            enable_matmul <= 1'b0;
        end else begin
            acc_prev      <= acc_done_wrap;
            rd_data_valid <= w_rd_en | n_rd_en;
            case (rd_fsm)
                S_IDLE: begin
                    if (rd_start) begin
                        rd_fsm        <= S_READ;
                        enable_matmul <= 1'b1;
                        k             <= k_next;
                        w_rd_en       <= beat_w_en;
                        w_rd_addra    <= beat_addra;
                        w_rd_addrb    <= beat_addrb;
                        n_rd_en       <= beat_n_en;
                        n_rd_addr     <= beat_naddr;
                    end
                end
                S_READ: begin
                    if (k == KW'(BURST - 1)) begin
                        rd_fsm     <= S_DRAIN;
                        w_rd_en    <= 1'b0;
                        w_rd_addra <= '0;
                        w_rd_addrb <= '0;
                        n_rd_en    <= 1'b0;
                        n_rd_addr  <= '0;
                    end else begin
                        k          <= k_next;
                        w_rd_en    <= beat_w_en;
                        w_rd_addra <= beat_addra;
                        w_rd_addrb <= beat_addrb;
                        n_rd_en    <= beat_n_en;
                        n_rd_addr  <= beat_naddr;
                    end
                end
                S_DRAIN: rd_fsm <= S_WAIT_ACC;
                S_WAIT_ACC: begin
                    if (acc_rise) begin
                        rd_fsm        <= S_IDLE;
                        rd_bank       <= ~rd_bank;
                        enable_matmul <= 1'b0;
                        k             <= '0;
                    end
                end
                default: rd_fsm <= S_IDLE;
            endcase
        end
    end

`ifdef PP_SCHED_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if ((wr_start & ~wr_ready) | (wr_done & (bank[wr_bank] != B_FILLING)))
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pp_bank_scheduler.sv
// Directed testbench for pp_bank_scheduler: a read-beat scoreboard plus state checks on two instances (4x4 and 2x4 column widths).
module tb_pp_bank_scheduler;
    localparam int AW = 4;

`ifdef PP_SCHED_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wr_start = 1'b0;
    logic wr_done = 1'b0;
    logic acc_done_wrap = 1'b0;

    logic          wr_ready, wr_bank, rd_bank, w_rd_en, n_rd_en, rd_data_valid, enable_matmul, err;
    logic [AW-1:0] w_rd_addra, w_rd_addrb, n_rd_addr;
    logic [3:0]    bank_state;

    logic          d2_wr_ready, d2_wr_bank, d2_rd_bank, d2_w_rd_en, d2_n_rd_en, d2_rd_data_valid, d2_enable_matmul, d2_err;
    logic [AW-1:0] d2_w_rd_addra, d2_w_rd_addrb, d2_n_rd_addr;
    logic [3:0]    d2_bank_state;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic          w_en;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic          n_en;
        logic [AW-1:0] na;
    } beat_t;

    beat_t q1[$];
    beat_t q2[$];

    pp_bank_scheduler #(.ADDR_WIDTH(AW), .W_COL_X(4), .N_COL_X(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr_start(wr_start), .wr_done(wr_done),
        .wr_ready(wr_ready), .wr_bank(wr_bank), .acc_done_wrap(acc_done_wrap),
        .rd_bank(rd_bank), .w_rd_en(w_rd_en), .w_rd_addra(w_rd_addra), .w_rd_addrb(w_rd_addrb),
        .n_rd_en(n_rd_en), .n_rd_addr(n_rd_addr), .rd_data_valid(rd_data_valid),
        .enable_matmul(enable_matmul), .bank_state(bank_state), .err(err)
    );

    pp_bank_scheduler #(.ADDR_WIDTH(AW), .W_COL_X(2), .N_COL_X(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_start(wr_start), .wr_done(wr_done),
        .wr_ready(d2_wr_ready), .wr_bank(d2_wr_bank), .acc_done_wrap(acc_done_wrap),
        .rd_bank(d2_rd_bank), .w_rd_en(d2_w_rd_en), .w_rd_addra(d2_w_rd_addra), .w_rd_addrb(d2_w_rd_addrb),
        .n_rd_en(d2_n_rd_en), .n_rd_addr(d2_n_rd_addr), .rd_data_valid(d2_rd_data_valid),
        .enable_matmul(d2_enable_matmul), .bank_state(d2_bank_state), .err(d2_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t makeBeat(int w, int n, int k);
        beat_t b;
        b.w_en = (k < w);
        b.a    = b.w_en ? AW'(k) : '0;
        b.b    = b.w_en ? AW'(w + k) : '0;
        b.n_en = (k < n);
        b.na   = b.n_en ? AW'(k) : '0;
        return b;
    endfunction

    task automatic pushBurst();
        for (int k = 0; k < 4; k++) begin
            q1.push_back(makeBeat(4, 4, k));
            q2.push_back(makeBeat(2, 4, k));
        end
    endtask

    // One clock, then pop and compare any read beat each instance presents.
    task automatic stepClock();
        beat_t obs;
        beat_t exp;
        @(posedge clk);
        #1;
        if (w_rd_en | n_rd_en) begin
            obs = beat_t'({w_rd_en, w_rd_addra, w_rd_addrb, n_rd_en, n_rd_addr});
            exp = (q1.size() > 0) ? q1.pop_front() : '0;
            checkOutput("read_beat", 32'(obs), 32'(exp));
        end
        if (d2_w_rd_en | d2_n_rd_en) begin
            obs = beat_t'({d2_w_rd_en, d2_w_rd_addra, d2_w_rd_addrb, d2_n_rd_en, d2_n_rd_addr});
            exp = (q2.size() > 0) ? q2.pop_front() : '0;
            checkOutput("d2_read_beat", 32'(obs), 32'(exp));
        end
    endtask

    task automatic applyStimulus(input logic s, input logic d, input logic a);
        wr_start      = s;
        wr_done       = d;
        acc_done_wrap = a;
        stepClock();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_bank_state", bank_state, 4'b0000);
        checkOutput("rst_wr_ready", wr_ready, 1'b1);
        checkOutput("rst_wr_bank", wr_bank, 1'b0);
        checkOutput("rst_rd_bank", rd_bank, 1'b0);
        checkOutput("rst_enable_matmul", enable_matmul, 1'b0);
        checkOutput("rst_err", err, 1'b0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0);

        // Fill bank0 and watch the first burst
        applyStimulus(1, 0, 0);
        checkOutput("filling_bank0", bank_state, 4'b0001);
        repeat (3) applyStimulus(0, 0, 0);
        pushBurst();
        applyStimulus(0, 1, 0);
        checkOutput("full_bank0", bank_state, 4'b0010);
        checkOutput("wr_bank_toggle", wr_bank, 1'b1);
        checkOutput("matmul_idle", enable_matmul, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 0);
            checkOutput($sformatf("rd_data_valid_%0d", i), rd_data_valid, (i >= 1 && i <= 4));
        end
        checkOutput("busy_bank0", bank_state, 4'b0011);
        checkOutput("matmul_wait", enable_matmul, 1'b1);
        checkOutput("beats_left_1", q1.size(), 0);
        checkOutput("d2_beats_left_1", q2.size(), 0);

        // Both banks occupied, illegal write, then release
        applyStimulus(1, 0, 0);
        checkOutput("filling_bank1", bank_state, 4'b0111);
        applyStimulus(0, 1, 0);
        checkOutput("both_full", bank_state, 4'b1011);
        checkOutput("both_full_wr_ready", wr_ready, 1'b0);
        checkOutput("err_before", err, 1'b0);
        applyStimulus(1, 0, 0);
        checkOutput("err_after_bad_start", err, ERR_EXP);
        checkOutput("bad_start_no_change", bank_state, 4'b1011);
        pushBurst();
        applyStimulus(0, 0, 1);
        checkOutput("release_bank0", bank_state, 4'b1000);
        checkOutput("release_rd_bank", rd_bank, 1'b1);
        checkOutput("release_wr_ready", wr_ready, 1'b1);
        checkOutput("release_matmul", enable_matmul, 1'b0);

        // Held-high acc_done_wrap must not release a second time
        repeat (7) applyStimulus(0, 0, 1);
        checkOutput("level_ignored", bank_state, 4'b1100);
        checkOutput("level_matmul", enable_matmul, 1'b1);
        checkOutput("beats_left_2", q1.size(), 0);
        applyStimulus(1, 0, 1);
        applyStimulus(0, 1, 1);
        applyStimulus(0, 0, 0);
        checkOutput("bank0_full_bank1_busy", bank_state, 4'b1110);
        checkOutput("wr_ready_blocked", wr_ready, 1'b0);

        // Release with simultaneous wr_start: rejected now, accepted next cycle alongside read start
        pushBurst();
        applyStimulus(1, 0, 1);
        checkOutput("release_bank1", bank_state, 4'b0010);
        checkOutput("release1_wr_ready", wr_ready, 1'b1);
        checkOutput("release1_rd_bank", rd_bank, 1'b0);
        applyStimulus(1, 0, 1);
        checkOutput("dual_transition", bank_state, 4'b0111);
        repeat (5) applyStimulus(0, 0, 0);
        checkOutput("beats_left_3", q1.size(), 0);
        checkOutput("d2_beats_left_3", q2.size(), 0);

        // wr_done on bank1 in the same cycle bank0 is released
        pushBurst();
        applyStimulus(0, 1, 1);
        checkOutput("done_and_release", bank_state, 4'b1000);
        checkOutput("done_release_wr_bank", wr_bank, 1'b0);
        checkOutput("done_release_rd_bank", rd_bank, 1'b1);
        repeat (3) applyStimulus(0, 0, 0);
        checkOutput("k2_addra", w_rd_addra, 4'd2);
        checkOutput("k2_naddr", n_rd_addr, 4'd2);
        checkOutput("d2_k2_w_en", d2_w_rd_en, 1'b0);
        checkOutput("d2_k2_n_en", d2_n_rd_en, 1'b1);

        // Asynchronous reset mid-burst
        rst_n = 1'b0;
        #1;
        checkOutput("arst_bank_state", bank_state, 4'b0000);
        checkOutput("arst_w_rd_en", w_rd_en, 1'b0);
        checkOutput("arst_addra", w_rd_addra, 4'd0);
        checkOutput("arst_addrb", w_rd_addrb, 4'd0);
        checkOutput("arst_naddr", n_rd_addr, 4'd0);
        checkOutput("arst_n_rd_en", n_rd_en, 1'b0);
        checkOutput("arst_valid", rd_data_valid, 1'b0);
        checkOutput("arst_matmul", enable_matmul, 1'b0);
        checkOutput("arst_err", err, 1'b0);
        checkOutput("arst_rd_bank", rd_bank, 1'b0);
        checkOutput("arst_wr_ready", wr_ready, 1'b1);
        q1.delete();
        q2.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 0, 0);
        checkOutput("post_rst_wr_ready", wr_ready, 1'b1);
        checkOutput("post_rst_matmul", enable_matmul, 1'b0);
        applyStimulus(1, 0, 0);
        checkOutput("post_rst_fill", bank_state, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pp_bank_scheduler.md
PP_BANK_SCHEDULER -- requirements
Module: pp_bank_scheduler

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, 4, bank address width; W_COL_X, 4, west words per row; N_COL_X, 4, north words per bank; BURST = max(W_COL_X, N_COL_X), derived.
REQ-002 SHALL use one clock; reset is asynchronous and active-low: clk input 1 rising-edge clock; rst_n input 1 async active-low reset.
REQ-003 SHALL have wr_start input 1: producer begins filling granted bank; wr_done input 1: producer finished filling granted bank.
REQ-004 SHALL have wr_ready output 1: granted bank is EMPTY; wr_bank output 1: bank index granted to producer.
REQ-005 SHALL have acc_done_wrap input 1: consumer accumulation done (level, edge-detected internally).
REQ-006 SHALL have rd_bank output 1: bank being read; w_rd_en output 1; w_rd_addra, w_rd_addrb output ADDR_WIDTH each; n_rd_en output 1; n_rd_addr output ADDR_WIDTH.
REQ-007 SHALL have rd_data_valid output 1: read data present at bank outputs; enable_matmul output 1: systolic array enable.
REQ-008 SHALL have bank_state output 4: {bank1[1:0], bank0[1:0]} encoded EMPTY=0, FILLING=1, FULL=2, BUSY=3; err output 1: sticky protocol error.

Function
REQ-009 SHALL keep per-bank state; EMPTY->FILLING on accepted wr_start; FILLING->FULL on wr_done; FULL->BUSY on read start; BUSY->EMPTY on release.
REQ-010 SHALL drive wr_ready = (state[wr_bank]==EMPTY) from registered state only; wr_start accepted only when wr_ready=1.
REQ-011 SHALL toggle wr_bank in the cycle wr_done is accepted; wr_done accepted only when state[wr_bank]==FILLING.
REQ-012 SHALL run read FSM S_IDLE, S_READ, S_DRAIN, S_WAIT_ACC; S_IDLE->S_READ when state[rd_bank]==FULL.
REQ-013 SHALL in S_READ count k=0..BURST-1, one per cycle: w_rd_en=(k<W_COL_X), w_rd_addra=k, w_rd_addrb=W_COL_X+k; n_rd_en=(k<N_COL_X), n_rd_addr=k; disabled ports drive address 0.
REQ-014 SHALL go S_READ->S_DRAIN after k=BURST-1; S_DRAIN lasts 1 cycle; then S_WAIT_ACC.
REQ-015 SHALL assert rd_data_valid exactly 1 cycle after each cycle with w_rd_en|n_rd_en (1-cycle BRAM latency).
REQ-016 SHALL assert enable_matmul in S_READ, S_DRAIN, S_WAIT_ACC; low in S_IDLE.
REQ-017 SHALL in S_WAIT_ACC on acc_done_wrap rising edge set state[rd_bank]=EMPTY, toggle rd_bank, go S_IDLE; acc_done_wrap edges outside S_WAIT_ACC are ignored.
REQ-018 SHALL apply write-side and read-side transitions in the same cycle when they target different banks; both take effect.
REQ-019 SHALL, if a bank is released and wr_start arrives the same cycle, not accept wr_start (wr_ready was 0); acceptance occurs next cycle.
REQ-020 SHALL, with both banks FULL, hold wr_ready=0 until a release; no write overrun possible.
REQ-021 SHALL set err on wr_start with wr_ready=0, or wr_done with state[wr_bank]!=FILLING; offending event otherwise ignored; err cleared only by reset.
REQ-022 SHALL keep k counter width $clog2(BURST)+1 so no wrap before BURST-1.

Reset
REQ-023 SHALL on rst_n=0 asynchronously set: both banks EMPTY, wr_bank=0, rd_bank=0, FSM S_IDLE, k=0, edge-detect register 0, all enables/valids/enable_matmul/err 0, all addresses 0.
REQ-024 SHALL on reset mid-burst abandon the burst; wr_ready=1 in first cycle after release of rst_n.

Configuration
REQ-025 SHALL use macro PP_SCHED_ERR_EN: defined -> err logic per REQ-021; undefined -> err tied 0, illegal events still ignored silently.

Verification
REQ-026 SHALL cover: reset, wr_start, 3 idle, wr_done -> bank_state=4'b0010, wr_bank=1, next cycle S_READ, w_rd_addra 0,1,2,3, w_rd_addrb 4,5,6,7, rd_data_valid cycles 2..5 after read start.
REQ-027 SHALL cover: W_COL_X=2, N_COL_X=4 -> w_rd_en high k=0,1 only, n_rd_en high k=0..3, BURST=4.
REQ-028 SHALL cover: fill bank0 and bank1, no acc_done -> bank_state=4'b1011, wr_ready=0; acc_done_wrap rise -> bank0 EMPTY, rd_bank=1, wr_ready=1 next cycle.
REQ-029 SHALL cover: wr_done on bank1 in same cycle as bank0 release -> bank_state=4'b1000 after edge, both transitions applied.
REQ-030 SHALL cover: wr_start while wr_ready=0 -> err=1 (with PP_SCHED_ERR_EN), bank_state unchanged; without macro err=0.
REQ-031 SHALL cover: rst_n low at k=2 of burst -> all outputs at reset values asynchronously, bank_state=0.
